// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter and its burst sequencer.
// Block geometry, state/owner encodings and the base-address helpers live here.
package mem_arbiter_pkg;

    localparam int WORDS  = 8;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Byte-offset bits inside one 16-byte block
    localparam logic [ADDR_W-1:0] BLOCK_OFS_MASK = 16'h000F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic logic [ADDR_W-1:0] fill_base(input logic [ADDR_W-1:0] addr);
        return addr & ~BLOCK_OFS_MASK;
    endfunction

    function automatic logic [ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_burst_seq.sv
// Burst sequencer: issues the 8 read requests of a block fill and counts returned words.
// Counters are held at zero whenever no fill is active, so each fill starts clean.
module mem_burst_seq
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active_i,
    input  logic             rvalid_i,
    output logic             issue_o,
    output logic [IDX_W-1:0] issue_idx_o,
    output logic [IDX_W-1:0] rcv_idx_o,
    output logic             last_o
);

    // Extra MSB on the issue counter marks "all words issued"
    logic [IDX_W:0]   issue_q, issue_d;
    logic [IDX_W-1:0] rcv_q, rcv_d;

    always_comb begin
        issue_o = active_i && !issue_q[IDX_W];
        issue_d = issue_q;
        rcv_d   = rcv_q;
        if (!active_i) begin
            issue_d = '0;
            rcv_d   = '0;
        end else begin
            if (issue_o) begin
                issue_d = issue_q + 1'b1;
            end
            if (rvalid_i) begin
                rcv_d = rcv_q + 1'b1;
            end
        end
    end

    assign issue_idx_o = issue_q[IDX_W-1:0];
    assign rcv_idx_o   = rcv_q;
    assign last_o      = active_i && rvalid_i && (rcv_q == IDX_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q <= '0;
            rcv_q   <= '0;
        end else begin
            issue_q <= issue_d;
            rcv_q   <= rcv_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the shared main memory: grants I/D cache requests, latches the
// transaction, runs the block burst or single write, and steers returned words.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_fill_valid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_fill_valid,
    output logic              d_done,
    output logic [DATA_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy
);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_owner_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;

    logic             grant_d, grant_i;
    logic             fill_active;
    logic             issue;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] rcv_idx;
    logic             last_word;

    // D wins ties unless D had the previous grant and I is waiting
    assign grant_d = d_req && !(i_req && (last_owner_q == OWN_D));
    assign grant_i = i_req && !grant_d;

    assign fill_active = (state_q == ST_FILL);

    mem_burst_seq u_burst (
        .clk         (clk),
        .rst_n       (rst_n),
        .active_i    (fill_active),
        .rvalid_i    (mem_rvalid),
        .issue_o     (issue),
        .issue_idx_o (issue_idx),
        .rcv_idx_o   (rcv_idx),
        .last_o      (last_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            base_q       <= '0;
            wdata_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        owner_q      <= OWN_D;
                        last_owner_q <= OWN_D;
                        base_q       <= d_wr ? word_base(d_addr) : fill_base(d_addr);
                        wdata_q      <= d_wdata;
                        state_q      <= d_wr ? ST_WRITE : ST_FILL;
                    end else if (grant_i) begin
                        owner_q      <= OWN_I;
                        last_owner_q <= OWN_I;
                        base_q       <= fill_base(i_addr);
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (last_word) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_WRITE: state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (issue) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + {{(ADDR_W-IDX_W-1){1'b0}}, issue_idx, 1'b0};
                end
                i_fill_valid = mem_rvalid && (owner_q == OWN_I);
                d_fill_valid = mem_rvalid && (owner_q == OWN_D);
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = base_q;
                mem_wdata = wdata_q;
            end
            ST_DONE: begin
                i_done = (owner_q == OWN_I);
                d_done = (owner_q == OWN_D);
            end
            default: ;
        endcase
    end

    assign fill_data = mem_rdata;
    assign fill_idx  = rcv_idx;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_fill_valid, i_done, d_fill_valid, d_done;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rvalid;
    logic        busy;

    logic        stray_v;
    logic [15:0] stray_d;
    bit   [3:0]  pv;
    bit   [15:0] pd [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_fill_valid (i_fill_valid),
        .i_done       (i_done),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_fill_valid (d_fill_valid),
        .d_done       (d_done),
        .fill_data    (fill_data),
        .fill_idx     (fill_idx),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .busy         (busy)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory: a read issued in cycle c returns in cycle c+4; not reset by rst_n
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en & ~mem_wr};
        pd[0] <= mem_word(mem_addr);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign mem_rvalid = pv[3] | stray_v;
    assign mem_rdata  = stray_v ? stray_d : pd[3];

    function automatic logic [63:0] snap();
        return {22'b0, mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done, busy,
                fill_idx, mem_addr, mem_wdata};
    endfunction

    function automatic logic [63:0] mk(input bit en, input bit wr, input bit ifv, input bit dfv,
                                       input bit idn, input bit ddn, input bit bsy,
                                       input logic [2:0] idx, input logic [15:0] addr,
                                       input logic [15:0] wd);
        return {22'b0, en, wr, ifv, dfv, idn, ddn, bsy, idx, addr, wd};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        repeat (ncyc) begin
            step();
            chk("reset outputs", snap(), 64'd0);
        end
        rst_n = 1'b1;
    endtask

    // Current cycle is the grant cycle G; checks G+1..G+13 of a block fill
    task automatic observe_fill(input bit own_d, input logic [15:0] base, input bit re_i, input bit re_d);
        bit          en, fv, dn;
        logic [15:0] a;
        logic [2:0]  idx;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            step();
            if (cyc == 1 && re_i) i_req = 1'b1;
            if (cyc == 1 && re_d) d_req = 1'b1;
            en  = (cyc <= 8);
            a   = en ? base + 16'(2 * (cyc - 1)) : 16'h0;
            fv  = (cyc >= 5) && (cyc <= 12);
            idx = fv ? 3'(cyc - 5) : 3'd0;
            dn  = (cyc == 13);
            chk($sformatf("fill %s base %h cyc %0d", own_d ? "D" : "I", base, cyc), snap(),
                mk(en, 1'b0, fv & ~own_d, fv & own_d, dn & ~own_d, dn & own_d, 1'b1, idx, a, 16'h0));
            if (fv) begin
                chk($sformatf("fill data base %h word %0d", base, cyc - 5), {48'b0, fill_data},
                    {48'b0, mem_word(base + 16'(2 * (cyc - 5)))});
            end
        end
    endtask

    task automatic observe_write(input logic [15:0] base, input logic [15:0] wd);
        step();
        chk($sformatf("write issue %h", base), snap(), mk(1, 1, 0, 0, 0, 0, 1, 3'd0, base, wd));
        step();
        chk($sformatf("write done %h", base), snap(), mk(0, 0, 0, 0, 0, 1, 1, 3'd0, 16'h0, 16'h0));
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_base;
    } vec_t;

    task automatic run_txn(input vec_t v);
        if (v.is_d) begin
            d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        chk("idle before grant", snap(), 64'd0);
        if (v.wr) observe_write(v.exp_base, v.wdata);
        else      observe_fill(v.is_d, v.exp_base, 1'b0, 1'b0);
        step();
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        chk("idle after done", snap(), 64'd0);
    endtask

    vec_t vecs [7];

    initial begin
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        stray_v = 1'b0; stray_d = 16'h0;

        vecs[0] = '{1'b0, 1'b0, 16'h123A, 16'h0000, 16'h1230};
        vecs[1] = '{1'b1, 1'b1, 16'h0051, 16'hBEEF, 16'h0050};
        vecs[2] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 16'h4000};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFE};
        vecs[5] = '{1'b1, 1'b0, 16'h800F, 16'h0000, 16'h8000};
        vecs[6] = '{1'b1, 1'b1, 16'h1234, 16'hA5A5, 16'h1234};

        // Reset, idle, stray rvalid
        do_reset(2);
        step();
        chk("idle after reset", snap(), 64'd0);
        stray_v = 1'b1; stray_d = 16'h1234;
        #1;
        chk("stray rvalid ignored", snap(), 64'd0);
        chk("fill_data pass-through", {48'b0, fill_data}, {48'b0, 16'h1234});
        step();
        stray_v = 1'b0;

        // Single-requester transactions
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
        end

        // Contention from reset: D first, then I, then D again
        do_reset(1);
        step();
        i_req = 1'b1; i_addr = 16'h123A;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4000;
        chk("contention idle", snap(), 64'd0);
        observe_fill(1'b1, 16'h4000, 1'b0, 1'b0);
        step();
        d_req = 1'b0;
        chk("handover to I", snap(), 64'd0);
        observe_fill(1'b0, 16'h1230, 1'b0, 1'b1);
        step();
        i_req = 1'b0;
        chk("handover to D", snap(), 64'd0);
        observe_fill(1'b1, 16'h4000, 1'b1, 1'b0);
        step();
        i_req = 1'b0; d_req = 1'b0;
        chk("contention end", snap(), 64'd0);
        step();
        chk("contention quiet", snap(), 64'd0);

        // Reset at word 3 of an I fill while memory is still returning words
        i_req = 1'b1; i_addr = 16'h2468;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
        end
        chk("pre-abort word 3", {60'b0, i_fill_valid, fill_idx}, {60'b0, 1'b1, 3'd3});
        rst_n = 1'b0; i_req = 1'b0;
        step();
        chk("abort outputs", snap(), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("late rvalid %0d", k), snap(), 64'd0);
        end
        run_txn('{1'b0, 1'b0, 16'h2468, 16'h0000, 16'h2460});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single shared multi-cycle main memory behind the instruction cache and the data cache.
- Accepts block-fill requests from both caches and single-word write-through requests from the D-cache.
- Arbitrates between them, then sequences the 8-word burst into memory and steers the returned words back to the owning cache.
- Sits between the cache miss handlers and the main memory model, outside the five-stage pipeline.

Parameters:
WORDS, 8, 16-bit words per cache block (block = 16 bytes)
ADDR_W, 16, address width (byte address)
IDX_W, 3, log2(WORDS)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_req  in  1  I-cache fill request; held high until i_done
i_addr  in  16  I-cache miss address
i_fill_valid  out  1  fill_data is a word for the I-cache this cycle
i_done  out  1  one-cycle pulse: I fill complete
d_req  in  1  D-cache request; held high until d_done
d_wr  in  1  1 = single-word write, 0 = block fill
d_addr  in  16  D-side address
d_wdata  in  16  write data
d_fill_valid  out  1  fill_data is a word for the D-cache this cycle
d_done  out  1  one-cycle pulse: D operation complete
fill_data  out  16  returned memory word (shared by both caches)
fill_idx  out  3  word index within block of fill_data
mem_en  out  1  memory request issue
mem_wr  out  1  memory write
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
mem_rvalid  in  1  mem_rdata valid (memory has fixed 4-cycle pipelined read latency)
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, issue count, receive count, owner and last_owner (=I) cleared. All outputs 0 except pass-through fill_data.
- Reset asserted mid-operation aborts immediately. Any mem_rvalid arriving after reset is ignored.
- States: IDLE, FILL, WRITE, DONE.
- IDLE arbitration when both requests are pending:
  - If last_owner = D and an I fill is pending, grant I; otherwise grant D.
  - A lone request is granted immediately.
- At grant, latch owner, op, base and wdata, and update last_owner:
  - Fill base = addr with bits [3:0] cleared.
  - Write base = addr with bit 0 cleared.
  - Requester address changes after grant are ignored.
- Grant d_req & d_wr -> WRITE. Grant any fill -> FILL. Requests are sampled only in IDLE.
- FILL, issue side:
  - Issue count k runs 0..7 on consecutive cycles from the first FILL cycle.
  - For k = 0..7: mem_en = 1, mem_wr = 0, mem_addr = base + 2k. No issue after k = 7.
- FILL, receive side:
  - Each mem_rvalid increments the receive count r.
  - fill_idx = r, fill_data = mem_rdata.
  - Owner's fill_valid = mem_rvalid; the other requester's fill_valid stays 0.
  - After the r = 7 word, go to DONE.
  - Issue and receive overlap: r tracks rvalid, not a cycle count.
- WRITE: one cycle with mem_en = 1, mem_wr = 1, mem_addr = base, mem_wdata = latched wdata; next state DONE.
- DONE:
  - The owner's done pulses for exactly one cycle; next state IDLE.
  - The requester deasserts its req in the cycle after done. The arbiter re-samples that requester only from that cycle on.
- Latency, grant in cycle G:
  - Fill: issues G+1..G+8, words G+5..G+12, done G+13, next grant possible G+14.
  - Write: issue G+1, done G+2.
- mem_rvalid outside FILL is ignored. No fill_valid is raised while IDLE, WRITE or DONE.
- mem_en is never asserted in IDLE or DONE.
- Only one owner at a time. i_* and d_* outputs are never both active in the same cycle.

Decomposition:
- Shared package: state encoding (IDLE/FILL/WRITE/DONE), owner encoding (OWN_I/OWN_D), WORDS/IDX_W constants, BLOCK_OFS_MASK.
- One natural sub-module, mem_burst_seq: issue counter plus receive counter plus done detect.
- The top level keeps the arbitration, latches and steering.

Test Plan:
- Reset then idle: rst_n low 2 cycles, no reqs -> all outputs 0, busy 0; stray mem_rvalid produces no fill_valid.
- I-only fill, i_addr = 0x123A: mem_addr 0x1230,0x1232,...,0x123E on G+1..G+8 -> i_fill_valid with fill_idx 0..7 at G+5..G+12, i_done at G+13, d_* stay 0.
- Simultaneous i_req and d_req (d_wr = 0, d_addr = 0x4000) from reset -> D granted first. I is granted in the first IDLE cycle after d_done, and its fill is addressed at I's base.
- D write, d_addr = 0x0051, d_wdata = 0xBEEF -> a single mem_en & mem_wr with mem_addr 0x0050, mem_wdata 0xBEEF at G+1, d_done at G+2, no fill_valid.
- Back-to-back contention (both held, each requester deasserts for one cycle after its done, then reasserts) -> grants alternate D, I, D.
- rst_n low at word 3 of a fill, memory still returning words -> next cycle IDLE, all outputs 0, late rvalids ignored. A fresh i_req then completes a full 8-word fill correctly.
